// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply/divide with HI/LO result registers
// Optional macro MULDIV_EARLY_TERM_EN: multiply stops once the remaining multiplier is zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clck,
  input  logic             reset_n,
  input  logic [1:0]       MulCtrl,
  input  logic [1:0]       DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy,
  output logic             done,
  output logic             DivZeroOP
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     mplier;
  logic [WIDTH:0]     divisor;
  logic [CW-1:0]      cnt;
  logic               sign_a;
  logic               sign_b;
  logic               is_div;
  logic               div_zero;

  // One extra bit so the magnitude of the most negative operand is representable.
  logic [WIDTH:0] a_ext, b_ext, abs_a, abs_b;
  assign a_ext = {A[WIDTH-1], A};
  assign b_ext = {B[WIDTH-1], B};
  assign abs_a = A[WIDTH-1] ? -a_ext : a_ext;
  assign abs_b = B[WIDTH-1] ? -b_ext : b_ext;

  logic               start;
  logic               mul_req;
  assign mul_req = (MulCtrl == 2'b01);
  assign start   = mul_req || (DivCtrl == 2'b01);

  logic [2*WIDTH-1:0] mul_next;
  logic               mul_last;
  assign mul_next = mplier[0] ? acc + mcand : acc;
`ifdef MULDIV_EARLY_TERM_EN
  assign mul_last = (mplier[WIDTH:1] == '0);
`else
  assign mul_last = (cnt == CW'(WIDTH - 1));
`endif

  // acc holds {remainder, quotient}; dividend bits enter from the top of mcand.
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  assign div_trial = {acc[2*WIDTH-1:WIDTH], mcand[WIDTH-1]};
  assign div_ge    = (div_trial >= divisor);
  assign div_rem   = div_ge ? WIDTH'(div_trial - divisor) : div_trial[WIDTH-1:0];
  assign div_next  = {div_rem, acc[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  assign prod_s = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_s  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_s  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clck or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      divisor   <= '0;
      cnt       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      is_div    <= 1'b0;
      div_zero  <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      DivZeroOP <= 1'b0;
    end else begin
      done      <= 1'b0;
      DivZeroOP <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand    <= {{(WIDTH-1){1'b0}}, abs_a};
            mplier   <= abs_b;
            divisor  <= abs_b;
            sign_a   <= A[WIDTH-1];
            sign_b   <= B[WIDTH-1];
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            is_div   <= !mul_req;
            div_zero <= 1'b0;
            if (mul_req) begin
              state <= S_MUL;
`ifdef MULDIV_EARLY_TERM_EN
              if (abs_b == '0) state <= S_FIX;
`endif
            end else if (B == '0) begin
              div_zero <= 1'b1;
              state    <= S_FIX;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          acc    <= mul_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) state <= S_FIX;
        end
        S_DIV: begin
          acc   <= div_next;
          mcand <= mcand << 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
          if (div_zero) begin
            DivZeroOP <= 1'b1;
          end else if (is_div) begin
            Hi <= rem_s;
            Lo <= quo_s;
          end else begin
            Hi <= prod_s[2*WIDTH-1:WIDTH];
            Lo <= prod_s[WIDTH-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (reference model plus directed vectors)
module tb_mult_div_unit;

  logic        clck = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  MulCtrl = 2'b00;
  logic [1:0]  DivCtrl = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Hi, Lo;
  logic        busy, done, DivZeroOP;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clck(clck), .reset_n(reset_n), .MulCtrl(MulCtrl), .DivCtrl(DivCtrl),
    .A(A), .B(B), .Hi(Hi), .Lo(Lo), .busy(busy), .done(done), .DivZeroOP(DivZeroOP)
  );

  always #5 clck = ~clck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from signed integer semantics.
  function automatic logic [63:0] ref_result(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mul) return sa * sb;
    if (sb == 0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Edges from the start edge to the edge on which results appear.
  function automatic int ref_latency(input logic is_mul, input logic [31:0] b);
    longint ab;
    int m;
    if (!is_mul) return (b == 32'd0) ? 1 : 33;
`ifdef MULDIV_EARLY_TERM_EN
    ab = longint'($signed(b));
    if (ab < 0) ab = -ab;
    if (ab == 0) return 1;
    m = 0;
    for (int i = 0; i < 33; i++) if (ab[i]) m = i;
    return m + 2;
`else
    ab = 0;
    m = 0;
    return 33 + int'(ab) + m;
`endif
  endfunction

  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, pend_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] pend = '0;
  int          left = 0;

  always @(posedge clck or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; left <= 0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_busy) begin
        if (left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_dz   <= pend_dz;
          if (!pend_dz) begin
            m_hi <= pend[63:32];
            m_lo <= pend[31:0];
          end
        end else begin
          left <= left - 1;
        end
      end else if (MulCtrl == 2'b01 || DivCtrl == 2'b01) begin
        pend    <= ref_result(MulCtrl == 2'b01, A, B);
        pend_dz <= (MulCtrl != 2'b01) && (B == 32'd0);
        left    <= ref_latency(MulCtrl == 2'b01, B);
        m_busy  <= 1'b1;
      end
    end
  end

  always @(negedge clck) begin
    check("cyc_busy", 32'(busy), 32'(m_busy));
    check("cyc_done", 32'(done), 32'(m_done));
    check("cyc_divzero", 32'(DivZeroOP), 32'(m_dz));
    check("cyc_hi", Hi, m_hi);
    check("cyc_lo", Lo, m_lo);
  end

  task automatic start_now(input logic [1:0] mc, input logic [1:0] dc, input logic [31:0] a, input logic [31:0] b);
    MulCtrl = mc; DivCtrl = dc; A = a; B = b;
    @(negedge clck);
    MulCtrl = 2'b00; DivCtrl = 2'b00;
  endtask

  task automatic start_op(input logic [1:0] mc, input logic [1:0] dc, input logic [31:0] a, input logic [31:0] b);
    @(negedge clck);
    start_now(mc, dc, a, b);
  endtask

  task automatic wait_done(input string name, input logic [31:0] eh, input logic [31:0] el,
                           input logic edz, input int elat);
    int n = 1;
    @(negedge clck);
    while (done !== 1'b1 && n < 100) begin
      @(negedge clck);
      n++;
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(elat));
    check({name, "_hi"}, Hi, eh);
    check({name, "_lo"}, Lo, el);
    check({name, "_divzero"}, 32'(DivZeroOP), 32'(edz));
  endtask

  int dn;

  initial begin
    repeat (3) @(negedge clck);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", Hi, 32'd0);
    check("reset_lo", Lo, 32'd0);
    reset_n = 1'b1;

    start_op(2'b01, 2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul_7_m3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, ref_latency(1'b1, 32'hFFFF_FFFD));
    @(negedge clck);
    check("mul_7_m3_done_clear", 32'(done), 32'd0);

    start_op(2'b01, 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done("mul_maxpos", 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, ref_latency(1'b1, 32'h7FFF_FFFF));
    start_now(2'b01, 2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mul_minneg", 32'h4000_0000, 32'h0000_0000, 1'b0, ref_latency(1'b1, 32'h8000_0000));

    start_op(2'b00, 2'b01, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    start_op(2'b00, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_m1", 32'h0000_0000, 32'h8000_0000, 1'b0, 33);

    start_op(2'b01, 2'b00, 32'd6, 32'd715827883);
    wait_done("preload", 32'h0000_0001, 32'h0000_0002, 1'b0, ref_latency(1'b1, 32'd715827883));
    start_op(2'b00, 2'b01, 32'd5, 32'd0);
    wait_done("div_zero", 32'h0000_0001, 32'h0000_0002, 1'b1, 1);
    @(negedge clck);
    check("div_zero_clear", 32'(DivZeroOP), 32'd0);

    start_op(2'b01, 2'b01, 32'd6, 32'd4);
    repeat (4) @(negedge clck);
    DivCtrl = 2'b01; A = 32'd100; B = 32'd7;
    @(negedge clck);
    DivCtrl = 2'b00;
    dn = 0;
    for (int i = 0; i < 80; i++) begin
      if (done === 1'b1) begin
        dn++;
        check("collide_lo", Lo, 32'd24);
        check("collide_hi", Hi, 32'd0);
      end
      @(negedge clck);
    end
    check("collide_done_count", 32'(dn), 32'd1);

    start_op(2'b01, 2'b00, 32'd1000, 32'd2000);
    repeat (10) @(negedge clck);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_hi", Hi, 32'd0);
    check("midreset_lo", Lo, 32'd0);
    repeat (2) @(negedge clck);
    reset_n = 1'b1;
    start_op(2'b01, 2'b00, 32'd3, 32'd5);
    wait_done("mul_3_5", 32'd0, 32'd15, 1'b0, ref_latency(1'b1, 32'd5));
    repeat (3) @(negedge clck);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
